mips_mc_control_fsm: RTL and testbench

- Main control unit for the multicycle MIPS core (CoreMips).
- Sequences the shared datapath (PC, IR, unified memory, register file, ALU) through Fetch/Decode/Execute/Memory/Writeback, one state per `clk` cycle.
- Driven from the divided board clock; `en` allows single-step/clock-enable operation from GPIO.
- Outputs are Moore-decoded from a registered state; write strobes are gated by `en`.

---
 rtl/mips_mc_control_fsm.sv | 187 ++++++++++++++++++
 tb/tb_mips_mc_control_fsm.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control_fsm.sv
// Multicycle MIPS main control: one state per enabled clk, Moore-decoded outputs.
// Write strobes, instr_done and illegal are suppressed whenever en is low.
module mips_mc_control_fsm #(
  parameter int ORI_EN  = 1,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [5:0]         opcode,
  output logic               pc_write,
  output logic               branch,
  output logic               ir_write,
  output logic               mem_write,
  output logic               reg_write,
  output logic               iord,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               zext,
  output logic               instr_done,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    S_INIT   = STATE_W'(0),
    S_FETCH  = STATE_W'(1),
    S_DECODE = STATE_W'(2),
    S_MEMADR = STATE_W'(3),
    S_MEMRD  = STATE_W'(4),
    S_MEMWB  = STATE_W'(5),
    S_MEMWR  = STATE_W'(6),
    S_EXEC   = STATE_W'(7),
    S_ALUWB  = STATE_W'(8),
    S_BEQ    = STATE_W'(9),
    S_ADDIEX = STATE_W'(10),
    S_IMMWB  = STATE_W'(11),
    S_JUMP   = STATE_W'(12),
    S_ORIEX  = STATE_W'(13)
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t state_q, state_d;
  logic   op_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    op_bad     = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    zext       = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          OP_ORI: begin
            state_d = (ORI_EN != 0) ? S_ORIEX : S_FETCH;
            op_bad  = (ORI_EN == 0);
          end
          default: begin
            state_d = S_FETCH;
            op_bad  = 1'b1;
          end
        endcase
        instr_done = op_bad;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // IR still holds lw or sw here; only those two opcodes reach this state
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ORIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        zext      = 1'b1;
        state_d   = S_IMMWB;
      end
      default: state_d = S_FETCH;
    endcase
    // Single-step hold: freeze the state and kill every side-effecting strobe
    if (!en) begin
      state_d    = state_q;
      pc_write   = 1'b0;
      branch     = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign illegal = en & op_bad;
  assign state   = state_q;

endmodule

// File: tb/tb_mips_mc_control_fsm.sv
// Scoreboard bench for mips_mc_control_fsm: expected state/outputs queued per cycle.
module tb_mips_mc_control_fsm;

  typedef struct {
    logic [3:0] st;
    logic       en;
    logic       ill;
    int         sel;
  } item_t;

  logic       clk = 1'b0;
  logic       rst, rst2, en;
  logic [5:0] opcode;
  logic       pcw[2], br[2], irw[2], mw[2], rw[2], iord[2], asa[2];
  logic       rd[2], m2r[2], zx[2], dn[2], il[2];
  logic [1:0] asb[2], aop[2], psrc[2];
  logic [3:0] st[2];

  item_t sb[$];
  int    nvec = 0;
  int    nerr = 0;

  always #5 clk = ~clk;

  mips_mc_control_fsm #(.ORI_EN(1), .STATE_W(4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode),
    .pc_write(pcw[0]), .branch(br[0]), .ir_write(irw[0]), .mem_write(mw[0]),
    .reg_write(rw[0]), .iord(iord[0]), .alu_src_a(asa[0]), .alu_src_b(asb[0]),
    .alu_op(aop[0]), .pc_src(psrc[0]), .reg_dst(rd[0]), .mem_to_reg(m2r[0]),
    .zext(zx[0]), .instr_done(dn[0]), .illegal(il[0]), .state(st[0])
  );

  mips_mc_control_fsm #(.ORI_EN(0), .STATE_W(4)) u_dut_noori (
    .clk(clk), .rst(rst2), .en(en), .opcode(opcode),
    .pc_write(pcw[1]), .branch(br[1]), .ir_write(irw[1]), .mem_write(mw[1]),
    .reg_write(rw[1]), .iord(iord[1]), .alu_src_a(asa[1]), .alu_src_b(asb[1]),
    .alu_op(aop[1]), .pc_src(psrc[1]), .reg_dst(rd[1]), .mem_to_reg(m2r[1]),
    .zext(zx[1]), .instr_done(dn[1]), .illegal(il[1]), .state(st[1])
  );

  function automatic logic [17:0] got_outs(int i);
    return {pcw[i], br[i], irw[i], mw[i], rw[i], iord[i], asa[i], asb[i],
            aop[i], psrc[i], rd[i], m2r[i], zx[i], dn[i], il[i]};
  endfunction

  // Expected Moore outputs straight from the per-state output table
  function automatic logic [17:0] exp_outs(logic [3:0] s, logic e, logic ill);
    logic pw, b, iw, mwr, rwr, io, sa, rdst, mtr, z, d, ilg;
    logic [1:0] sb2, op2, ps2;
    {pw, b, iw, mwr, rwr, io, sa, rdst, mtr, z, d, ilg} = '0;
    {sb2, op2, ps2} = '0;
    case (s)
      4'd1:  begin iw = 1; pw = 1; sb2 = 2'b01; end
      4'd2:  begin sb2 = 2'b11; d = ill; ilg = ill; end
      4'd3:  begin sa = 1; sb2 = 2'b10; end
      4'd4:  io = 1;
      4'd5:  begin rwr = 1; mtr = 1; d = 1; end
      4'd6:  begin io = 1; mwr = 1; d = 1; end
      4'd7:  begin sa = 1; op2 = 2'b10; end
      4'd8:  begin rwr = 1; rdst = 1; d = 1; end
      4'd9:  begin sa = 1; op2 = 2'b01; ps2 = 2'b01; b = 1; d = 1; end
      4'd10: begin sa = 1; sb2 = 2'b10; end
      4'd11: begin rwr = 1; d = 1; end
      4'd12: begin pw = 1; ps2 = 2'b10; d = 1; end
      4'd13: begin sa = 1; sb2 = 2'b10; op2 = 2'b11; z = 1; end
      default: ;
    endcase
    if (!e) {pw, b, iw, mwr, rwr, d, ilg} = '0;
    return {pw, b, iw, mwr, rwr, io, sa, sb2, op2, ps2, rdst, mtr, z, d, ilg};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] s, input logic e, input logic ill, input int sel);
    item_t it;
    it.st = s; it.en = e; it.ill = ill; it.sel = sel;
    sb.push_back(it);
  endtask

  task automatic drain();
    item_t it;
    while (sb.size() > 0) begin
      @(negedge clk);
      it = sb.pop_front();
      check_val($sformatf("dut%0d state exp %0d", it.sel, it.st), 32'(st[it.sel]), 32'(it.st));
      check_val($sformatf("dut%0d outs in state %0d", it.sel, it.st),
                32'(got_outs(it.sel)), 32'(exp_outs(it.st, it.en, it.ill)));
    end
  endtask

  // Enters FETCH on the next edge, then expects the given state sequence
  task automatic instr(input logic [5:0] op, input int n, input logic [31:0] seq,
                       input logic ill_op, input int sel);
    logic [3:0] s;
    @(posedge clk);
    #1 opcode = op;
    for (int i = 0; i < n; i++) begin
      s = seq[4*(n-1-i) +: 4];
      push(s, 1'b1, ill_op && (s == 4'd2), sel);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1; en = 1'b1; opcode = 6'b000000;
    for (int i = 0; i < 3; i++) push(4'd0, 1'b1, 1'b0, 0);
    drain();
    @(posedge clk);
    #1 rst = 1'b0;
    push(4'd0, 1'b1, 1'b0, 0);
    drain();

    instr(6'b100011, 5, 32'h12345, 1'b0, 0);   // lw
    instr(6'b101011, 4, 32'h1236,  1'b0, 0);   // sw
    instr(6'b000100, 3, 32'h129,   1'b0, 0);   // beq
    instr(6'b001101, 4, 32'h12DB,  1'b0, 0);   // ori
    instr(6'b001000, 4, 32'h12AB,  1'b0, 0);   // addi
    instr(6'b111111, 2, 32'h12,    1'b1, 0);   // illegal
    instr(6'b000000, 4, 32'h1278,  1'b0, 0);   // R-type
    instr(6'b000010, 3, 32'h12C,   1'b0, 0);   // j

    // Single-step hold in MEMWR
    @(posedge clk);
    #1 opcode = 6'b101011;
    push(4'd1, 1'b1, 1'b0, 0); push(4'd2, 1'b1, 1'b0, 0); push(4'd3, 1'b1, 1'b0, 0);
    drain();
    @(posedge clk);
    #1 en = 1'b0;
    for (int i = 0; i < 4; i++) push(4'd6, 1'b0, 1'b0, 0);
    drain();
    @(posedge clk);
    #1 en = 1'b1;
    push(4'd6, 1'b1, 1'b0, 0);
    drain();

    // Asynchronous reset in the middle of ALUWB
    instr(6'b000000, 4, 32'h1278, 1'b0, 0);
    #2 rst = 1'b1;
    #1;
    check_val("async rst state", 32'(st[0]), 32'd0);
    check_val("async rst reg_write", 32'(rw[0]), 32'd0);
    check_val("async rst outs", 32'(got_outs(0)), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    push(4'd0, 1'b1, 1'b0, 0);
    drain();
    instr(6'b000010, 3, 32'h12C, 1'b0, 0);

    // ori on the ORI_EN=0 instance decodes as illegal
    @(posedge clk);
    #1 begin rst = 1'b1; rst2 = 1'b0; end
    push(4'd0, 1'b1, 1'b0, 1);
    drain();
    instr(6'b001101, 3, 32'h121, 1'b1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
